// File: rtl/zl_ts_pkg.sv
// zl_ts_pkg -- shared constants, FSM encodings and helpers for the TS mux.
//   SYNC_BYTE / PKT_LEN : default MPEG-TS sync value and packet length
//   NULL_HDR0..3        : header bytes of an inserted null packet (PID 0x1FFF)
//   NULL_FILL           : payload fill byte of a null packet
//   sync_state_t        : HUNT / CHECK / LOCK alignment FSM
//   out_state_t         : BOUNDARY / PASS / NULL output FSM
package zl_ts_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'h47;
   localparam int         PKT_LEN   = 188;

   localparam logic [7:0] NULL_HDR0 = 8'h47;
   localparam logic [7:0] NULL_HDR1 = 8'h1F;
   localparam logic [7:0] NULL_HDR2 = 8'hFF;
   localparam logic [7:0] NULL_HDR3 = 8'h10;
   localparam logic [7:0] NULL_FILL = 8'hFF;

   typedef enum logic [1:0] {
      S_HUNT  = 2'd0,
      S_CHECK = 2'd1,
      S_LOCK  = 2'd2
   } sync_state_t;

   typedef enum logic [1:0] {
      O_BOUNDARY = 2'd0,
      O_PASS     = 2'd1,
      O_NULL     = 2'd2
   } out_state_t;

   // Byte index advance, wrapping from pkt_len-1 back to 0.
   function automatic logic [7:0] idx_next(input logic [7:0] idx, input int pkt_len);
      if (int'(idx) >= pkt_len - 1) return 8'd0;
      return idx + 8'd1;
   endfunction

   // Content of a null packet at a given byte index.
   function automatic logic [7:0] null_byte(input logic [7:0] idx);
      logic [7:0] b;
      case (idx)
         8'd0:    b = NULL_HDR0;
         8'd1:    b = NULL_HDR1;
         8'd2:    b = NULL_HDR2;
         8'd3:    b = NULL_HDR3;
         default: b = NULL_FILL;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/zl_ts_sync.sv
// zl_ts_sync -- packet alignment FSM (HUNT / CHECK / LOCK).
//   clk, rst      : clock, asynchronous active-high reset
//   in_req_i      : input byte valid
//   in_data_i     : input byte
//   in_ack_i      : final input ack as driven to the source (transfer = req & ack)
//   sof_i         : a passed packet's byte 0 transferred this cycle (LOCK only)
//   sof_bad_i     : that byte 0 was not the sync byte
//   eof_i         : a passed packet's last byte transferred this cycle
//   sync_ack_o    : ack this FSM wants while the output side is not passing
//   lock_o        : registered LOCK indication
//   state_o       : current state, for debug
// Before LOCK this block owns the input stream and tracks its own byte index.
// Once locked, the output FSM owns the input and reports packet start/end.
module zl_ts_sync
   import zl_ts_pkg::*;
#(
   parameter int         Pkt_len      = PKT_LEN,
   parameter logic [7:0] Sync_byte    = SYNC_BYTE,
   parameter int         Lock_count   = 3,
   parameter int         Unlock_count = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_req_i,
   input  logic [7:0] in_data_i,
   input  logic       in_ack_i,
   input  logic       sof_i,
   input  logic       sof_bad_i,
   input  logic       eof_i,
   output logic       sync_ack_o,
   output logic       lock_o,
   output logic [1:0] state_o
);

   sync_state_t state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  good_q, good_d;
   logic [7:0]  bad_q, bad_d;

   logic is_sync;
   logic good_lt;
   logic xfer;

   assign is_sync = (in_data_i == Sync_byte);
   // True while another consumed sync is still needed before locking.
   assign good_lt = (int'(good_q) + 1) < Lock_count;
   assign xfer    = in_req_i & in_ack_i;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_HUNT;
         idx_q   <= 8'd0;
         good_q  <= 8'd0;
         bad_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      good_d  = good_q;
      bad_d   = bad_q;
      case (state_q)
         S_HUNT: begin
            if (xfer && is_sync) begin
               state_d = S_CHECK;
               idx_d   = idx_next(8'd0, Pkt_len);
               good_d  = 8'd1;
            end
         end
         S_CHECK: begin
            if (idx_q != 8'd0) begin
               if (xfer) idx_d = idx_next(idx_q, Pkt_len);
            end else if (in_req_i) begin
               if (!is_sync) begin
                  if (xfer) begin
                     state_d = S_HUNT;
                     idx_d   = 8'd0;
                     good_d  = 8'd0;
                  end
               end else if (good_lt) begin
                  if (xfer) begin
                     good_d = good_q + 8'd1;
                     idx_d  = idx_next(idx_q, Pkt_len);
                  end
               end else begin
                  // Final sync is left un-acked so the output side passes it.
                  state_d = S_LOCK;
                  idx_d   = 8'd0;
                  good_d  = 8'd0;
                  bad_d   = 8'd0;
               end
            end
         end
         S_LOCK: begin
            if (sof_i) begin
               if (sof_bad_i) bad_d = (bad_q == 8'hFF) ? bad_q : bad_q + 8'd1;
               else           bad_d = 8'd0;
            end
            // Loss of lock only takes effect once the current packet has completed.
            if (eof_i && (int'(bad_d) >= Unlock_count)) begin
               state_d = S_HUNT;
               idx_d   = 8'd0;
               good_d  = 8'd0;
               bad_d   = 8'd0;
            end
         end
         default: state_d = S_HUNT;
      endcase
   end

   // Outputs
   always_comb begin
      sync_ack_o = 1'b0;
      case (state_q)
         S_HUNT:  sync_ack_o = 1'b1;
         S_CHECK: sync_ack_o = (idx_q != 8'd0) || !is_sync || good_lt;
         default: sync_ack_o = 1'b0;
      endcase
   end

   assign lock_o  = (state_q == S_LOCK);
   assign state_o = state_q;

endmodule

// File: rtl/zl_ts_mux.sv
// zl_ts_mux -- MPEG-TS pass-through with alignment check and null insertion.
//   clk, rst        : clock, asynchronous active-high reset
//   in_data/in_req  : byte stream from the USB FIFO; in_ack accepts it
//   out_data/out_req: byte stream to the DVB-S core; out_ack accepts it
//   null_en         : allow null packets when no aligned input is available
//   lock            : input stream is packet-aligned
//   pkt_count       : passed packets (wraps at 16 bits)
//   null_count      : inserted null packets (wraps at 16 bits)
//   sync_err        : bad sync bytes seen while locked (saturates at 255)
//   dbg_out_state   : output FSM state
//   dbg_sync_state  : alignment FSM state
// Handshake: on each side a byte moves only in a cycle where req and ack are
// both high; req may be raised without waiting for ack, and ack may be high
// without req (no transfer then).
// PASS is a zero-latency combinational path; a packet, once begun, always
// runs to full length, and the output FSM decides at each boundary whether to
// pass, insert a null packet, or idle.
module zl_ts_mux
   import zl_ts_pkg::*;
#(
   parameter int         Pkt_len      = PKT_LEN,
   parameter logic [7:0] Sync_byte    = SYNC_BYTE,
   parameter int         Lock_count   = 3,
   parameter int         Unlock_count = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_req,
   output logic        in_ack,
   output logic [7:0]  out_data,
   output logic        out_req,
   input  logic        out_ack,
   input  logic        null_en,
   output logic        lock,
   output logic [15:0] pkt_count,
   output logic [15:0] null_count,
   output logic [7:0]  sync_err,
   output logic [1:0]  dbg_out_state,
   output logic [1:0]  dbg_sync_state
);

   out_state_t  state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] null_cnt_q, null_cnt_d;
   logic [7:0]  sync_err_q, sync_err_d;

   logic eff_pass;
   logic eff_null;
   logic out_xfer;
   logic last_byte;
   logic pass_sof;
   logic pass_eof;
   logic null_eof;
   logic sof_bad;
   logic sync_ack;

   zl_ts_sync #(
      .Pkt_len      (Pkt_len),
      .Sync_byte    (Sync_byte),
      .Lock_count   (Lock_count),
      .Unlock_count (Unlock_count)
   ) u_sync (
      .clk        (clk),
      .rst        (rst),
      .in_req_i   (in_req),
      .in_data_i  (in_data),
      .in_ack_i   (in_ack),
      .sof_i      (pass_sof),
      .sof_bad_i  (sof_bad),
      .eof_i      (pass_eof),
      .sync_ack_o (sync_ack),
      .lock_o     (lock),
      .state_o    (dbg_sync_state)
   );

   // From BOUNDARY the chosen mode takes effect in the same cycle, so a
   // packet's byte 0 can transfer without an idle cycle in between.
   assign eff_pass = (state_q == O_PASS) ||
                     ((state_q == O_BOUNDARY) && lock && in_req);
   assign eff_null = (state_q == O_NULL) ||
                     ((state_q == O_BOUNDARY) && !(lock && in_req) && null_en);

   assign last_byte = (idx_q == 8'(Pkt_len - 1));
   assign out_xfer  = out_req & out_ack;
   assign sof_bad   = (in_data != Sync_byte);
   assign pass_sof  = eff_pass & out_xfer & (idx_q == 8'd0);
   assign pass_eof  = eff_pass & out_xfer & last_byte;
   assign null_eof  = eff_null & out_xfer & last_byte;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= O_BOUNDARY;
         idx_q      <= 8'd0;
         pkt_cnt_q  <= 16'd0;
         null_cnt_q <= 16'd0;
         sync_err_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pkt_cnt_q  <= pkt_cnt_d;
         null_cnt_q <= null_cnt_d;
         sync_err_q <= sync_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         O_BOUNDARY: begin
            if (eff_pass)      state_d = O_PASS;
            else if (eff_null) state_d = O_NULL;
         end
         O_PASS:  state_d = O_PASS;
         O_NULL:  state_d = O_NULL;
         default: state_d = O_BOUNDARY;
      endcase
      if (out_xfer) begin
         if (last_byte) begin
            state_d = O_BOUNDARY;
            idx_d   = 8'd0;
         end else begin
            idx_d = idx_next(idx_q, Pkt_len);
         end
      end
   end

   // Statistics
   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      null_cnt_d = null_cnt_q;
      sync_err_d = sync_err_q;
      if (pass_eof) pkt_cnt_d  = pkt_cnt_q + 16'd1;
      if (null_eof) null_cnt_d = null_cnt_q + 16'd1;
      if (pass_sof && sof_bad && (sync_err_q != 8'hFF)) sync_err_d = sync_err_q + 8'd1;
   end

   // Outputs; everything is held quiet while reset is asserted.
   always_comb begin
      out_req  = 1'b0;
      out_data = 8'd0;
      in_ack   = 1'b0;
      if (!rst) begin
         if (eff_pass) begin
            out_req  = in_req;
            out_data = (idx_q == 8'd0) ? Sync_byte : in_data;
            in_ack   = out_ack;
         end else begin
            // Not passing: the alignment FSM decides; it never acks in LOCK.
            in_ack = sync_ack;
            if (eff_null) begin
               out_req  = 1'b1;
               out_data = null_byte(idx_q);
            end
         end
      end
   end

   assign pkt_count     = pkt_cnt_q;
   assign null_count    = null_cnt_q;
   assign sync_err      = sync_err_q;
   assign dbg_out_state = state_q;

endmodule
